// File: rtl/mac_vec_engine.sv
// Streaming signed multiply-accumulate engine: one dot-product per vector of (a,b) beats,
// with a registered product stage, optional saturation, sticky overflow and a beat-length guard.
module mac_vec_engine #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 19,
  parameter int VEC_LEN  = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     macc_clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_ovf,
  output logic                     out_len_err
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W + 1 - PROD_W;
  localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VEC_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                     stall;
  logic                     accept;
  logic                     cnt_full;
  logic signed [PROD_W-1:0] product;

  logic [ACC_W:0]           prod_r;
  logic                     prod_v;
  logic                     prod_last;
  logic                     prod_forced;
  logic [CNT_W-1:0]         beat_cnt;

  logic [ACC_W-1:0]         acc;
  logic                     ovf_sticky;
  logic [ACC_W:0]           sum;
  logic                     overflow;
  logic [ACC_W-1:0]         acc_next;

  // A pending result that downstream has not taken freezes both stages.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~macc_clear;
  assign accept   = in_valid & in_ready;
  assign cnt_full = (beat_cnt == CNT_MAX);
  assign product  = in_a * in_b;

  // One guard bit above the accumulator exposes overflow as a disagreement of the top two bits.
  assign sum      = {acc[ACC_W-1], acc} + prod_r;
  assign overflow = sum[ACC_W] ^ sum[ACC_W-1];

  // NOTE: the default assignment at the top of always_comb keeps every path driven, so no latch is inferred.
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (SATURATE && overflow) begin
      acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Stage 1: register the sign-extended product and decide whether this beat closes the vector.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r      <= '0;
      prod_v      <= 1'b0;
      prod_last   <= 1'b0;
      prod_forced <= 1'b0;
      beat_cnt    <= '0;
    end else if (macc_clear) begin
      prod_v      <= 1'b0;
      beat_cnt    <= '0;
    end else if (accept) begin
      prod_r      <= {{EXT_W{product[PROD_W-1]}}, product};
      prod_v      <= 1'b1;
      prod_last   <= in_last | cnt_full;
      prod_forced <= ~in_last & cnt_full;
      beat_cnt    <= (in_last | cnt_full) ? '0 : beat_cnt + CNT_W'(1);
    end else if (!stall) begin
      prod_v      <= 1'b0;
    end
  end

  // Stage 2: accumulate; on the closing beat publish the result and restart from zero without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      ovf_sticky  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_len_err <= 1'b0;
    end else if (macc_clear) begin
      acc         <= '0;
      ovf_sticky  <= 1'b0;
      out_valid   <= 1'b0;
      out_ovf     <= 1'b0;
      out_len_err <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (prod_v && !stall) begin
        if (prod_last) begin
          out_data    <= acc_next;
          out_valid   <= 1'b1;
          out_ovf     <= ovf_sticky | overflow;
          out_len_err <= prod_forced;
          acc         <= '0;
          ovf_sticky  <= 1'b0;
        end else begin
          acc         <= acc_next;
          ovf_sticky  <= ovf_sticky | overflow;
        end
      end
    end
  end

endmodule
